// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Multiplies finish after MUL_LAT stall cycles. Divides use a radix-2 restoring
// loop on operand magnitudes, followed by a sign fix-up. A flush cancels work
// in flight and never writes HI/LO.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_rd,
  output logic [31:0] lo_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [5:0] MUL_LAST    = 6'(MUL_LAT - 2);
  localparam logic [5:0] DIV_LAST    = 6'(DIV_ITERS - 1);
  localparam logic       MUL_STALLS  = (MUL_LAT > 1) ? 1'b1 : 1'b0;

  // Full 64-bit product; the signed case sign-extends both operands to 66 bits.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] p;
    ea = $signed({{34{sgn & a[31]}}, a});
    eb = $signed({{34{sgn & b[31]}}, b});
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Magnitude of a 32-bit operand (0x80000000 maps to itself as unsigned).
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn & x[31]) ? (32'd0 - x) : x;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;      // multiplicand, or dividend shifting into quotient
  logic [31:0] opb_q, opb_d;      // multiplier, or divisor magnitude
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic        sgn_q, sgn_d;      // signed multiply
  logic        negq_q, negq_d;    // negate quotient at fix-up
  logic        negr_q, negr_d;    // negate remainder at fix-up
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        is_mul_s, is_div_s, accept_s;
  logic [32:0] shifted_s, trial_s;
  logic        fits_s;
  logic [31:0] rem_next_s, quo_next_s;
  logic [63:0] prod_s, prod_req_s;

  assign is_mul_s = (req_op == OP_MULT) | (req_op == OP_MULTU);
  assign is_div_s = (req_op == OP_DIV)  | (req_op == OP_DIVU);
  assign accept_s = (state_q == ST_IDLE) & req_valid & ~flush & (is_mul_s | is_div_s);

  // One restoring iteration: shift in the next dividend bit and try the subtract.
  always_comb begin
    shifted_s  = {rem_q, opa_q[31]};
    trial_s    = shifted_s - {1'b0, opb_q};
    fits_s     = ~trial_s[32];
    rem_next_s = fits_s ? trial_s[31:0] : shifted_s[31:0];
    quo_next_s = {opa_q[30:0], fits_s};
    prod_s     = mul64(opa_q, opb_q, sgn_q);
    prod_req_s = mul64(req_a, req_b, (req_op == OP_MULT));
  end

  // Next-state, datapath and HI/LO update; flush overrides everything last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d = 6'd0;
          rem_d = 32'd0;
          if (is_mul_s) begin
            opa_d = req_a;
            opb_d = req_b;
            sgn_d = (req_op == OP_MULT);
            if (MUL_STALLS) begin
              state_d = ST_MUL;
            end else begin
              hi_d    = prod_req_s[63:32];
              lo_d    = prod_req_s[31:0];
              state_d = ST_DONE;
            end
          end else begin
            opa_d   = mag32(req_a, (req_op == OP_DIV));
            opb_d   = mag32(req_b, (req_op == OP_DIV));
            negq_d  = (req_op == OP_DIV) & (req_a[31] ^ req_b[31]);
            negr_d  = (req_op == OP_DIV) & req_a[31];
            state_d = ST_DIV;
          end
        end else if (req_valid & ~flush & (req_op == OP_MTHI)) begin
          hi_d = req_a;
        end else if (req_valid & ~flush & (req_op == OP_MTLO)) begin
          lo_d = req_a;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_q == MUL_LAST) begin
          hi_d    = prod_s[63:32];
          lo_d    = prod_s[31:0];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV: begin
        opa_d = quo_next_s;
        rem_d = rem_next_s;
        if (cnt_q == DIV_LAST) begin
          lo_d    = negq_q ? (32'd0 - quo_next_s) : quo_next_s;
          hi_d    = negr_q ? (32'd0 - rem_next_s) : rem_next_s;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end else begin
      cnt_d = cnt_d;
    end
    busy_d = (state_d == ST_MUL) | (state_d == ST_DIV);
  end

  // Pipeline hold: in-flight work, or a stalling op being accepted this cycle.
  always_comb begin
    if (flush) begin
      stall = 1'b0;
    end else if ((state_q == ST_MUL) | (state_q == ST_DIV)) begin
      stall = 1'b1;
    end else if (state_q == ST_IDLE) begin
      stall = req_valid & (is_div_s | (is_mul_s & MUL_STALLS));
    end else begin
      stall = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 32'd0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign hi_rd = hi_q;
  assign lo_rd = lo_q;

endmodule
